// File: rtl/num_display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment bytes are active-low, ordered {A,B,C,D,E,F,G,DP}.
package num_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'b11111111;
  localparam logic [7:0] SEG_DASH  = 8'b11111101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } cvt_state_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'b00000011;
      4'h1: s = 8'b10011111;
      4'h2: s = 8'b00100101;
      4'h3: s = 8'b00001101;
      4'h4: s = 8'b10011001;
      4'h5: s = 8'b01001001;
      4'h6: s = 8'b01000001;
      4'h7: s = 8'b00011011;
      4'h8: s = 8'b00000001;
      4'h9: s = 8'b00011001;
      4'hA: s = 8'b00010001;
      4'hB: s = 8'b11000001;
      4'hC: s = 8'b01100011;
      4'hD: s = 8'b10000101;
      4'hE: s = 8'b01100001;
      default: s = 8'b01110001;
    endcase
    return s;
  endfunction

  // Decimal digits needed to hold any VALUE_W-bit unsigned value.
  function automatic int bcd_digits(input int w);
    return (w * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/multi_digit_display_if.sv
// Load handshake between the value registers and the display converter.
interface multi_digit_display_if #(
  parameter int VALUE_W = 16
);
  logic [VALUE_W-1:0] value;
  logic               load;
  logic               hex_mode;
  logic               ready;
  logic               done;

  modport master (output value, load, hex_mode, input ready, done);
  modport slave  (input value, load, hex_mode, output ready, done);
endinterface

// File: rtl/multi_digit_display_bin2bcd_seq.sv
// Sequential double-dabble converter; hex mode bypasses the shifter.
// Digits and overflow only change at COMMIT, so the scan never sees partial sums.
module bin2bcd_seq
  import num_display_pkg::*;
#(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 4,
  localparam int BCD_D  = bcd_digits(VALUE_W),
  localparam int BCD_W  = 4 * BCD_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value_i,
  input  logic               load_i,
  input  logic               hex_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o,
  output logic               ovf_o
);
  localparam int CNT_W = $clog2(VALUE_W);

  cvt_state_e         state_q, state_d;
  logic [VALUE_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]   wrk_q, wrk_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d, done_q, done_d, hi_nz;

  // Hex nibbles and BCD digits share the working register, so one test covers both modes.
  generate
    if (DIGITS < BCD_D) begin : g_ovf
      assign hi_nz = |wrk_q[BCD_W-1:4*DIGITS];
    end else begin : g_noovf
      assign hi_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    adj = wrk_q;
    for (int n = 0; n < BCD_D; n++)
      if (wrk_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = wrk_q[4*n +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    wrk_d   = wrk_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (load_i) begin
        if (hex_i) begin
          wrk_d   = BCD_W'(value_i);
          state_d = ST_COMMIT;
        end else begin
          sh_d    = value_i;
          wrk_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        wrk_d = {adj[BCD_W-2:0], sh_q[VALUE_W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        bcd_d   = wrk_q;
        ovf_d   = hi_nz;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      wrk_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      wrk_q   <= wrk_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed common-anode 7-segment driver: refresh timer, digit scan,
// leading-zero blanking, decimal points and overflow dashes, all registered.
module multi_digit_display
  import num_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_digit_display_if.slave ld,
  input  logic                 blank_lz_i,
  input  logic [DIGITS-1:0]    dp_en_i,
  output logic [7:0]           seg_o,
  output logic [DIGITS-1:0]    an_o
);
  localparam int BCD_D = bcd_digits(VALUE_W);
  localparam int BCD_W = 4 * BCD_D;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BCD_W-1:0]           bcd;
  logic                       ovf;
  logic [DIGITS-1:0][3:0]     dig;
  logic [REF_W-1:0]           ref_q;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 seg_q, seg_d;
  logic [DIGITS-1:0]          an_q, an_d;
  logic                       wrap, lz;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) u_cvt (
    .clk     (clk),
    .rst     (rst),
    .value_i (ld.value),
    .load_i  (ld.load),
    .hex_i   (ld.hex_mode),
    .ready_o (ld.ready),
    .done_o  (ld.done),
    .bcd_o   (bcd),
    .ovf_o   (ovf)
  );

  // Digits beyond what the converter can produce read as zero.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      if (g < BCD_D) begin : g_src
        assign dig[g] = bcd[4*g +: 4];
      end else begin : g_zero
        assign dig[g] = 4'h0;
      end
    end
  endgenerate

  assign wrap = (ref_q == REF_W'(REFRESH_DIV - 1));

  always_comb begin
    lz = blank_lz_i && (idx_q != '0);
    for (int j = 0; j < DIGITS; j++)
      if ((IDX_W'(j) >= idx_q) && (dig[j] != 4'h0)) lz = 1'b0;
    if (ovf)
      seg_d = SEG_DASH;
    else begin
      seg_d = lz ? SEG_BLANK : seg_encode(dig[idx_q]);
      if (dp_en_i[idx_q]) seg_d[0] = 1'b0;
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // The digit under the scan pointer is latched on wrap, then the pointer moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else if (wrap) begin
      ref_q <= '0;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed bench for multi_digit_display (4 digits, 16-bit value, 4-cycle dwell).
module tb_multi_digit_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank_lz = 1'b0;
  logic [3:0] dp_en = 4'b0;
  logic [7:0] seg;
  logic [3:0] an;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] shown [4];

  multi_digit_display_if #(.VALUE_W(16)) ifc ();

  multi_digit_display #(.DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ifc),
    .blank_lz_i (blank_lz),
    .dp_en_i    (dp_en),
    .seg_o      (seg),
    .an_o       (an)
  );

  always #5 clk = ~clk;

  // Remember the last pattern driven onto each digit.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic [3:0] m;
      m = 4'b0001 << i;
      if (an == ~m) shown[i] = seg;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic h, input int lat);
    int got;
    chk("ready_before_load", ifc.ready, 1'b1);
    ifc.value = v; ifc.hex_mode = h; ifc.load = 1'b1;
    @(posedge clk); #1;
    ifc.load = 1'b0;
    chk("ready_low_after_accept", ifc.ready, 1'b0);
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n == 1 && ifc.done) begin got = 1; break; end
      if (n > 1 && ifc.done) begin got = n - 1; break; end
    end
    chk("done_latency", got, lat);
    chk("ready_at_done", ifc.ready, 1'b1);
  endtask

  task automatic settle_and_check(input string name, input logic [7:0] e0, input logic [7:0] e1,
                                  input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    repeat (24) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("%s_digit%0d", name, i), shown[i], e[i]);
  endtask

  typedef struct {
    logic [15:0] v;
    logic        hex;
    logic        lz;
    logic [3:0]  dp;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int seen;
    tbl[0]  = '{16'd1234,  1'b0, 1'b0, 4'b0000, 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};
    tbl[1]  = '{16'hBEEF,  1'b1, 1'b0, 4'b0000, 8'b01110001, 8'b01100001, 8'b01100001, 8'b11000001};
    tbl[2]  = '{16'd12345, 1'b0, 1'b0, 4'b0000, 8'b11111101, 8'b11111101, 8'b11111101, 8'b11111101};
    tbl[3]  = '{16'd7,     1'b0, 1'b1, 4'b0000, 8'b00011011, 8'hFF,       8'hFF,       8'hFF};
    tbl[4]  = '{16'd7,     1'b0, 1'b0, 4'b0000, 8'b00011011, 8'b00000011, 8'b00000011, 8'b00000011};
    tbl[5]  = '{16'd7,     1'b0, 1'b0, 4'b0010, 8'b00011011, 8'b00000010, 8'b00000011, 8'b00000011};
    tbl[6]  = '{16'd7,     1'b0, 1'b1, 4'b0010, 8'b00011011, 8'b11111110, 8'hFF,       8'hFF};
    tbl[7]  = '{16'd0,     1'b0, 1'b1, 4'b0000, 8'b00000011, 8'hFF,       8'hFF,       8'hFF};
    tbl[8]  = '{16'd9999,  1'b0, 1'b0, 4'b0000, 8'b00011001, 8'b00011001, 8'b00011001, 8'b00011001};
    tbl[9]  = '{16'h00A0,  1'b1, 1'b1, 4'b0000, 8'b00000011, 8'b00010001, 8'hFF,       8'hFF};
    tbl[10] = '{16'd65535, 1'b0, 1'b0, 4'b1111, 8'b11111101, 8'b11111101, 8'b11111101, 8'b11111101};
    tbl[11] = '{16'hFFFF,  1'b1, 1'b0, 4'b0000, 8'b01110001, 8'b01110001, 8'b01110001, 8'b01110001};
    tbl[12] = '{16'd1000,  1'b0, 1'b1, 4'b0000, 8'b00000011, 8'b00000011, 8'b00000011, 8'b10011111};

    ifc.value = '0; ifc.load = 1'b0; ifc.hex_mode = 1'b0;
    for (int i = 0; i < 4; i++) shown[i] = 8'h00;

    // Reset state and first scan slot.
    #12;
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 4'hF);
    chk("rst_ready", ifc.ready, 1'b1);
    chk("rst_done", ifc.done, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("an_idle_before_wrap", an, 4'hF);
    @(posedge clk); #1;
    chk("first_wrap_an", an, 4'b1110);
    chk("first_wrap_seg", seg, 8'b00000011);

    for (int t = 0; t < 13; t++) begin
      blank_lz = tbl[t].lz;
      dp_en    = tbl[t].dp;
      do_load(tbl[t].v, tbl[t].hex, tbl[t].hex ? 1 : 17);
      @(posedge clk); #1;
      chk("done_one_cycle", ifc.done, 1'b0);
      settle_and_check($sformatf("vec%0d", t), tbl[t].e0, tbl[t].e1, tbl[t].e2, tbl[t].e3);
    end

    // Back-to-back: second load accepted on the edge done drops.
    blank_lz = 1'b1; dp_en = 4'b0000;
    do_load(16'd5, 1'b0, 17);
    do_load(16'h0C3D, 1'b1, 1);
    settle_and_check("b2b", 8'b10000101, 8'b00001101, 8'b01100011, 8'hFF);

    // Ignored load during conversion, then reset aborts it mid-scan.
    blank_lz = 1'b0;
    ifc.value = 16'd9999; ifc.hex_mode = 1'b0; ifc.load = 1'b1;
    @(posedge clk); #1;
    ifc.load = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin ifc.value = 16'd42; ifc.load = 1'b1; end
      @(posedge clk); #1;
      ifc.load = 1'b0;
      if (ifc.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_busy", ifc.ready, 1'b0);
    rst = 1'b1; #1;
    chk("abort_seg", seg, 8'hFF);
    chk("abort_an", an, 4'hF);
    chk("abort_ready", ifc.ready, 1'b1);
    @(negedge clk); rst = 1'b0;
    settle_and_check("after_abort", 8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011);
    do_load(16'd42, 1'b0, 17);
    settle_and_check("load42", 8'b00100101, 8'b10011001, 8'b00000011, 8'b00000011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_digit_display.md
# multi_digit_display

Parametrised multiplexed 7-segment driver: accepts a binary value through a ready/valid load handshake, converts it to decimal (sequential double-dabble) or hex digits, and time-multiplexes DIGITS common-anode digits. Supersedes the fixed 4-digit driver. Adds leading-zero blanking, per-digit decimal points, an overflow indication and tear-free digit updates. Sits between CPU-visible value registers and the board display pins.

## Interface
- DIGITS, 4, number of display digits (1..8)
- VALUE_W, 16, input value width (4..32)
- REFRESH_DIV, 1000, clk cycles per digit dwell (>=1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- value  in  VALUE_W  binary value to display
- load  in  1  request to convert value; accepted when load && ready
- hex_mode  in  1  sampled with value: 1 = hex digits, 0 = decimal
- ready  out  1  converter idle, can accept load
- done  out  1  one-cycle pulse when new digits commit to display
- blank_lz  in  1  blank leading zeros (live, not latched)
- dp_en  in  DIGITS  dp_en[i]=1 lights DP of digit i (live)
- seg  out  8  active-low segments, [7]=A … [1]=G, [0]=DP
- an  out  DIGITS  active-low digit enables, an[0] = least significant digit

## Operation
- Converter FSM: IDLE → (load && ready) → capture value/hex_mode → SHIFT (decimal only, VALUE_W iterations, add-3 on any BCD nibble >= 5 before each shift) → COMMIT → IDLE. Hex skips SHIFT.
- Internal BCD width BCD_D = (VALUE_W*3)/10 + 1 digits; 16-bit gives 5 digits (max 65535).
- Overflow: decimal, any BCD digit at index >= DIGITS nonzero; hex, any value bit at index >= 4*DIGITS set. Overflow latches with the digits; all digits then show dash 8'b11111101, DP ignored.
- Display digits register updates only at COMMIT; the scan never shows partial results.
- load while ready=0 is ignored, with no queueing.
- Segment codes, DP bit = 1 (off): 0 00000011, 1 10011111, 2 00100101, 3 00001101, 4 10011001, 5 01001001, 6 01000001, 7 00011011, 8 00000001, 9 00011001, A 00010001, b 11000001, C 01100011, d 10000101, E 01100001, F 01110001, blank 11111111.
- blank_lz=1: digits above the most significant nonzero digit show blank; digit 0 is never blanked. Blanked digits still honour dp_en.
- dp_en[i]=1 clears seg[0] while digit i is scanned.
- Scan: refresh counter 0..REFRESH_DIV-1. On wrap, digit index advances 0→1→…→DIGITS-1→0 and an/seg load together on that edge.

## Timing
- Reset (async): seg=8'hFF, an=all ones, ready=1, done=0, digits=0, overflow=0, refresh counter=0, digit index=0, FSM=IDLE.
- After reset release, an stays all ones until the first wrap, REFRESH_DIV cycles later; then an[0]=0.
- Accept at edge k. Decimal: ready=0 from k, SHIFT on edges k+1..k+VALUE_W, COMMIT at edge k+VALUE_W+1 with done=1 and ready=1 in that cycle. Hex: COMMIT at edge k+1.
- The next load can be accepted on the same edge that done is deasserted (back-to-back).
- seg reflects new digits from the first scan edge after COMMIT.
- Reset mid-conversion aborts; the display returns to digits 0 and ready=1.
- REFRESH_DIV=1: digit advances every cycle.

## Structure
- Package num_display_pkg: segment constants (SEG_BLANK, SEG_DASH, digit table), function seg_encode(4-bit) → 8-bit, function bcd_digits(VALUE_W).
- Sub-module bin2bcd_seq: the converter FSM with load/ready/done, parametrised VALUE_W. It outputs BCD_D digits plus an overflow flag computed for DIGITS.
- Top multi_digit_display: refresh counter, scan index, blanking/DP muxing, registered seg/an.

## Test plan
- Bench parameters DIGITS=4, VALUE_W=16, REFRESH_DIV=4.
- Assert rst mid-scan → seg=8'hFF, an=4'hF, ready=1 immediately. Release → an=4'b1110, seg=00000011 after 4 cycles.
- Load 1234 decimal at edge k → ready low, done at k+17. Scan shows digit0 10011001, digit1 00001101, digit2 00100101, digit3 10011111.
- Load 16'hBEEF with hex_mode=1 → done at k+1. Digits 0..3 show F, E, E, b codes.
- Load 12345 decimal → overflow; all four digits 8'b11111101.
- Load 7 with blank_lz=1 → digit0 00011011, digits1-3 8'hFF. With blank_lz=0 → digits1-3 00000011. With dp_en=4'b0010 → digit1 seg[0]=0.
- Load 9999, pulse load=42 at k+5 (ignored), assert rst at k+10 → no done pulse, display 0, ready=1. Next load 42 → done at accept+17.
